// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops receiver FIFO bytes, tracks held key / ASCII / BCD press count, drives 6 hex digits.
// Key state updates 1 edge after the pop strobe and the display 1 edge later; one byte per 3 cycles, waits on ps2_ready.
module ps2_key_ctrl #(
  parameter int CNT_MAX    = 99,
  parameter bit HOLD_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_ready,
  input  logic        ps2_overflow,
  output logic        ps2_nextdata_n,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic [7:0]  key_ascii,
  output logic [7:0]  press_cnt,
  output logic [23:0] digits,
  output logic [5:0]  dig_en,
  output logic        err_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [3:0] MAX_TENS   = 4'(CNT_MAX / 10);
  localparam logic [3:0] MAX_ONES   = 4'(CNT_MAX % 10);

  state_e      state_q;
  logic [7:0]  byte_q;
  logic        nextdata_n_q;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  key_code_q, key_code_d;
  logic [7:0]  key_ascii_q, key_ascii_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        break_q, break_d;
  logic        ext_q, ext_d;
  logic        err_ovf_q;
  logic [23:0] digits_q;
  logic [5:0]  dig_en_q;

  function automatic logic [7:0] ascii_lut(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // BCD increment that wraps to 00 after CNT_MAX; ones never exceed 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] cnt);
    logic [7:0] r;
    if (cnt == {MAX_TENS, MAX_ONES})  r = 8'h00;
    else if (cnt[3:0] >= 4'd9)        r = {cnt[7:4] + 4'd1, 4'd0};
    else                              r = {cnt[7:4], cnt[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_ascii_d = key_ascii_q;
    cnt_d       = cnt_q;
    break_d     = break_q;
    ext_d       = ext_q;
    if (byte_q == BREAK_CODE) begin
      break_d = 1'b1;
    end else if (byte_q == EXT_CODE) begin
      ext_d = 1'b1;
    end else if (break_q) begin
      if (key_valid_q && (byte_q == key_code_q)) key_valid_d = 1'b0;
      break_d = 1'b0;
      ext_d   = 1'b0;
    end else begin
      // A repeat of the held key is typematic and must not count again.
      if (!(key_valid_q && (byte_q == key_code_q))) begin
        key_code_d  = byte_q;
        key_ascii_d = ext_q ? 8'h00 : ascii_lut(byte_q);
        key_valid_d = 1'b1;
        cnt_d       = bcd_inc(cnt_q);
      end
      ext_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ascii_q  <= 8'h00;
      cnt_q        <= 8'h00;
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      err_ovf_q    <= 1'b0;
      digits_q     <= 24'h0;
      dig_en_q     <= {2'b11, {4{~HOLD_BLANK}}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_ready) begin
            byte_q       <= ps2_data;
            nextdata_n_q <= 1'b0;
            state_q      <= ST_POP;
          end
        end
        ST_POP: begin
          nextdata_n_q <= 1'b1;
          key_valid_q  <= key_valid_d;
          key_code_q   <= key_code_d;
          key_ascii_q  <= key_ascii_d;
          cnt_q        <= cnt_d;
          break_q      <= break_d;
          ext_q        <= ext_d;
          state_q      <= ST_GAP;
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          nextdata_n_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
      // Overflow desynchronises the prefix stream, so pending prefixes are dropped.
      if (ps2_overflow) begin
        err_ovf_q <= 1'b1;
        break_q   <= 1'b0;
        ext_q     <= 1'b0;
      end
      digits_q <= {cnt_q, key_ascii_q, key_code_q};
      dig_en_q <= {2'b11, {4{key_valid_q | ~HOLD_BLANK}}};
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_ascii      = key_ascii_q;
  assign press_cnt      = cnt_q;
  assign digits         = digits_q;
  assign dig_en         = dig_en_q;
  assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: a byte FIFO model feeds scan codes, vector table plus hand-written corner sequences.
module tb_ps2_key_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  ps2_data;
  logic        ps2_ready;
  logic        ps2_overflow;
  logic        ps2_nextdata_n;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [7:0]  key_ascii;
  logic [7:0]  press_cnt;
  logic [23:0] digits;
  logic [5:0]  dig_en;
  logic        err_ovf;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.CNT_MAX(99), .HOLD_BLANK(1'b1)) dut (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ascii(key_ascii),
    .press_cnt(press_cnt), .digits(digits), .dig_en(dig_en), .err_ovf(err_ovf)
  );

  // Receiver FIFO model: the stimulus writes mem/wr_ptr, the pop process owns rd_ptr.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  int         pop_cnt   = 0;
  int         width_err = 0;
  logic       prev_low  = 1'b0;

  assign ps2_ready = (rd_ptr != wr_ptr);
  assign ps2_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (!resetn) begin
      rd_ptr   <= wr_ptr;
      prev_low <= 1'b0;
    end else begin
      prev_low <= !ps2_nextdata_n;
      if (!ps2_nextdata_n) begin
        rd_ptr  <= rd_ptr + 8'd1;
        pop_cnt <= pop_cnt + 1;
        if (prev_low) width_err <= width_err + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_key(input string tag, input logic v, input logic [7:0] code,
                         input logic [7:0] ascii, input logic [7:0] cnt);
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(v));
    chk({tag, ".key_code"},  32'(key_code),  32'(code));
    chk({tag, ".key_ascii"}, 32'(key_ascii), 32'(ascii));
    chk({tag, ".press_cnt"}, 32'(press_cnt), 32'(cnt));
    chk({tag, ".digits"},    32'(digits),    32'({cnt, ascii, code}));
    chk({tag, ".dig_en"},    32'(dig_en),    32'(v ? 6'b111111 : 6'b110000));
  endtask

  task automatic send(input logic [7:0] b);
    int old;
    int t;
    old = pop_cnt;
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
    t = 0;
    while (pop_cnt == old && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("pop_seen", 32'(pop_cnt != old), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic [7:0] code;
    logic [7:0] ascii;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input logic v, input logic [7:0] code,
                     input logic [7:0] ascii, input logic [7:0] cnt);
    vec_t x;
    x.b = b; x.v = v; x.code = code; x.ascii = ascii; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  initial begin
    int p0;
    int t;
    int m;
    logic [7:0] exp_cnt;

    resetn       = 1'b0;
    ps2_overflow = 1'b0;
    wr_ptr       = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // make/break, typematic, rollover, plain digit, extended prefix
    add(8'h1C, 1, 8'h1C, 8'h41, 8'h01);
    add(8'hF0, 1, 8'h1C, 8'h41, 8'h01);
    add(8'h1C, 0, 8'h1C, 8'h41, 8'h01);
    add(8'h1C, 1, 8'h1C, 8'h41, 8'h02);
    for (int i = 0; i < 4; i++) add(8'h1C, 1, 8'h1C, 8'h41, 8'h02);
    add(8'hF0, 1, 8'h1C, 8'h41, 8'h02);
    add(8'h1C, 0, 8'h1C, 8'h41, 8'h02);
    add(8'h1C, 1, 8'h1C, 8'h41, 8'h03);
    add(8'h32, 1, 8'h32, 8'h42, 8'h04);
    add(8'hF0, 1, 8'h32, 8'h42, 8'h04);
    add(8'h1C, 1, 8'h32, 8'h42, 8'h04);
    add(8'hF0, 1, 8'h32, 8'h42, 8'h04);
    add(8'h32, 0, 8'h32, 8'h42, 8'h04);
    add(8'h16, 1, 8'h16, 8'h31, 8'h05);
    add(8'hF0, 1, 8'h16, 8'h31, 8'h05);
    add(8'h16, 0, 8'h16, 8'h31, 8'h05);
    add(8'hE0, 0, 8'h16, 8'h31, 8'h05);
    add(8'h75, 1, 8'h75, 8'h00, 8'h06);
    add(8'hF0, 1, 8'h75, 8'h00, 8'h06);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    chk("rst.err_ovf", 32'(err_ovf), 32'd0);
    chk_key("rst", 0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    p0 = pop_cnt;
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].b);
      chk_key($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].ascii, vecs[i].cnt);
    end
    chk("pop_count", 32'(pop_cnt - p0), 32'(vecs.size()));
    chk("pop_width", 32'(width_err), 32'd0);

    // Overflow pulse drops the pending break, so the next 75 is a typematic make.
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf.set", 32'(err_ovf), 32'd1);
    send(8'h75);
    chk_key("ovf.repeat", 1, 8'h75, 8'h00, 8'h06);
    send(8'hF0);
    send(8'h75);
    chk_key("ovf.release", 0, 8'h75, 8'h00, 8'h06);
    chk("ovf.sticky", 32'(err_ovf), 32'd1);

    // Back-to-back bytes already queued in the FIFO.
    p0 = pop_cnt;
    mem[wr_ptr] = 8'h16; wr_ptr = wr_ptr + 8'd1;
    mem[wr_ptr] = 8'hF0; wr_ptr = wr_ptr + 8'd1;
    mem[wr_ptr] = 8'h16; wr_ptr = wr_ptr + 8'd1;
    repeat (16) @(negedge clk);
    chk("burst.pops", 32'(pop_cnt - p0), 32'd3);
    chk("burst.width", 32'(width_err), 32'd0);
    chk_key("burst", 0, 8'h16, 8'h31, 8'h07);

    // Reset while the pop strobe is low.
    p0 = pop_cnt;
    mem[wr_ptr] = 8'h1C; wr_ptr = wr_ptr + 8'd1;
    t = 0;
    while (ps2_nextdata_n !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("midpop.strobe_low", 32'(ps2_nextdata_n), 32'd0);
    resetn = 1'b0;
    #1;
    chk("midpop.nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    chk("midpop.err_ovf", 32'(err_ovf), 32'd0);
    chk_key("midpop", 0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("midpop.no_repop", 32'(pop_cnt - p0), 32'd0);
    chk("midpop.nextdata_idle", 32'(ps2_nextdata_n), 32'd1);

    // Counter wrap through 99 -> 00.
    m = 0;
    for (int i = 1; i <= 100; i++) begin
      send(8'h45);
      m = (m == 99) ? 0 : m + 1;
      exp_cnt = {4'(m / 10), 4'(m % 10)};
      chk($sformatf("wrap%0d.cnt", i), 32'(press_cnt), 32'(exp_cnt));
      chk($sformatf("wrap%0d.nib", i), 32'((press_cnt[3:0] <= 4'd9) && (press_cnt[7:4] <= 4'd9)), 32'd1);
      if (i == 99) chk("wrap.at99", 32'(press_cnt), 32'h99);
      send(8'hF0);
      send(8'h45);
    end
    chk_key("wrap.end", 0, 8'h45, 8'h30, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
